reg_writeback_queue: RTL

//   Write-side front end for the 32x32 register file.

---
 rtl/reg_writeback_queue.sv | 128 ++++++++++++
 1 files changed

// File: rtl/reg_writeback_queue.sv
// Ordered writeback queue between the ALU/load producers and the register file write port.
// Optional macro FORWARD_EN adds a combinational lookup of pending writes (fwd_reg/fwd_hit/fwd_data).
`timescale 1ns/1ps
module reg_writeback_queue #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic                     clock_in,
  input  logic                     reset_n,
  input  logic                     mem_valid,
  input  logic [ADDR_W-1:0]        mem_reg,
  input  logic [DATA_W-1:0]        mem_data,
  output logic                     mem_ready,
  input  logic                     alu_valid,
  input  logic [ADDR_W-1:0]        alu_reg,
  input  logic [DATA_W-1:0]        alu_data,
  output logic                     alu_ready,
  output logic [ADDR_W-1:0]        writeReg,
  output logic [DATA_W-1:0]        writeData,
  output logic                     regWrite,
`ifdef FORWARD_EN
  input  logic [ADDR_W-1:0]        fwd_reg,
  output logic                     fwd_hit,
  output logic [DATA_W-1:0]        fwd_data,
`endif
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]    count_q, count_d;
  logic [ADDR_W-1:0] reg_mem_q  [DEPTH];
  logic [DATA_W-1:0] data_mem_q [DEPTH];
  logic [ADDR_W-1:0] write_reg_q;
  logic [DATA_W-1:0] write_data_q;
  logic              reg_write_q;

  logic              full;
  logic              mem_acc;
  logic              alu_acc;
  logic              push;
  logic              pop;
  logic [ADDR_W-1:0] push_reg;
  logic [DATA_W-1:0] push_data;

  // Readiness uses start-of-cycle occupancy only, so a same-cycle pop never frees a slot.
  assign full      = (count_q == (PTR_W+1)'(DEPTH));
  assign mem_ready = !full;
  assign alu_ready = !full && !mem_valid;

  always_comb begin
    mem_acc   = mem_valid && !full;
    alu_acc   = alu_valid && !full && !mem_valid;
    push_reg  = mem_acc ? mem_reg  : alu_reg;
    push_data = mem_acc ? mem_data : alu_data;
    // Writes to r0 complete the handshake but are dropped.
    push      = (mem_acc || alu_acc) && (push_reg != '0);
    pop       = (count_q != '0);
    wr_ptr_d  = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d  = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d   = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + (PTR_W+1)'(1);
      2'b01:   count_d = count_q - (PTR_W+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock_in) begin
    if (push) begin
      reg_mem_q[wr_ptr_q]  <= push_reg;
      data_mem_q[wr_ptr_q] <= push_data;
    end
  end

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      write_reg_q  <= '0;
      write_data_q <= '0;
      reg_write_q  <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      reg_write_q <= pop;
      if (pop) begin
        write_reg_q  <= reg_mem_q[rd_ptr_q];
        write_data_q <= data_mem_q[rd_ptr_q];
      end
    end
  end

  assign writeReg  = write_reg_q;
  assign writeData = write_data_q;
  assign regWrite  = reg_write_q;
  assign count     = count_q;

`ifdef FORWARD_EN
  logic [PTR_W-1:0] fwd_idx;

  // Scan oldest to youngest so the last match wins; the output register is older than any queued entry.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    fwd_idx  = '0;
    if (fwd_reg != '0) begin
      if (reg_write_q && (write_reg_q == fwd_reg)) begin
        fwd_hit  = 1'b1;
        fwd_data = write_data_q;
      end
      for (int i = 0; i < DEPTH; i++) begin
        fwd_idx = rd_ptr_q + PTR_W'(i);
        if (((PTR_W+1)'(i) < count_q) && (reg_mem_q[fwd_idx] == fwd_reg)) begin
          fwd_hit  = 1'b1;
          fwd_data = data_mem_q[fwd_idx];
        end
      end
    end
  end
`endif

endmodule
